sreg_file: RTL and testbench

- Special-register (SREG) storage block: the receiving end of the writeback-stage SREG write interface.
- Holds per-privilege-level banked special registers addressed by group/regnum/plevel.
- Enforces write/read privilege and out-of-range checks; hosts the free-running cycle counter and the retired-instruction counter.
- Provides one registered read port, with write-to-read bypass, for the execute stage.

---
 rtl/sreg_file.sv | 150 +++++++++++++++
 tb/tb_sreg_file.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_file.sv
// Special-register file: banked SREG storage, privilege checks,
// cycle/instret counters and a registered read port with bypass.
package core;
  localparam int REG_WIDTH = 32;
endpackage

module sreg_file #(
  parameter int REG_WIDTH  = core::REG_WIDTH,
  parameter int NUM_GROUPS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cur_plevel,
  input  logic                 sreg_wr_en,
  input  logic [4:0]           sreg_wr_group,
  input  logic [2:0]           sreg_wr_regnum,
  input  logic [1:0]           sreg_wr_plevel,
  input  logic [REG_WIDTH-1:0] sreg_wr_val,
  input  logic                 retire_valid,
  input  logic                 rd_en,
  input  logic [4:0]           rd_group,
  input  logic [2:0]           rd_regnum,
  input  logic [1:0]           rd_plevel,
  output logic                 rd_valid,
  output logic [REG_WIDTH-1:0] rd_val,
  output logic                 rd_fault,
  output logic                 wr_fault
);

  localparam int NUM_LOC = NUM_GROUPS * 32;
  localparam int IW = $clog2(NUM_LOC);
  localparam logic [5:0] NG = 6'(NUM_GROUPS);

  typedef logic [REG_WIDTH-1:0] word_t;

  // Flat index: {group, regnum, plevel}; counter slots stay unused.
  function automatic logic [IW-1:0] loc(
    input logic [4:0] g,
    input logic [2:0] r,
    input logic [1:0] p
  );
    return IW'({g, r, p});
  endfunction

  // Group 0 regs 0/1 are the shared CYCLE/INSTRET counters.
  function automatic logic is_ctr(
    input logic [4:0] g,
    input logic [2:0] r
  );
    return (g == 5'd0) && (r[2:1] == 2'b00);
  endfunction

  word_t mem_q [NUM_LOC];
  word_t mem_d [NUM_LOC];
  word_t cycle_q, cycle_d;
  word_t instret_q, instret_d;
  logic  rd_valid_q, rd_valid_d;
  word_t rd_val_q, rd_val_d;
  logic  rd_fault_q, rd_fault_d;
  logic  wr_fault_q, wr_fault_d;

  logic wr_ok;
  logic wr_ctr;
  logic rd_bad;
  logic rd_ctr;
  logic same_loc;
  logic bypass;
  word_t rd_cur;

  // Request qualification and read-side source selection.
  always_comb begin
    wr_ok = sreg_wr_en
         && ({1'b0, sreg_wr_group} < NG)
         && (sreg_wr_plevel <= cur_plevel);
    wr_ctr = is_ctr(sreg_wr_group, sreg_wr_regnum);
    rd_bad = ({1'b0, rd_group} >= NG)
          || (rd_plevel > cur_plevel);
    rd_ctr = is_ctr(rd_group, rd_regnum);
    same_loc = (sreg_wr_group == rd_group)
            && (sreg_wr_regnum == rd_regnum)
            && (rd_ctr || (sreg_wr_plevel == rd_plevel));
    bypass = wr_ok && same_loc;
    rd_cur = mem_q[loc(rd_group, rd_regnum, rd_plevel)];
  end

  // Next state for storage, counters and write fault pulse.
  always_comb begin
    mem_d = mem_q;
    cycle_d = cycle_q + word_t'(1);
    instret_d = instret_q + word_t'(retire_valid);
    wr_fault_d = sreg_wr_en && !wr_ok;
    if (wr_ok) begin
      if (wr_ctr) begin
        if (sreg_wr_regnum[0]) instret_d = sreg_wr_val;
        else cycle_d = sreg_wr_val;
      end else begin
        mem_d[loc(sreg_wr_group, sreg_wr_regnum,
                  sreg_wr_plevel)] = sreg_wr_val;
      end
    end
  end

  // Read pipeline register next state.
  always_comb begin
    rd_valid_d = rd_en;
    rd_fault_d = 1'b0;
    rd_val_d = rd_val_q;
    if (rd_en) begin
      priority case (1'b1)
        rd_bad: begin
          rd_fault_d = 1'b1;
          rd_val_d = '0;
        end
        bypass: rd_val_d = sreg_wr_val;
        (rd_ctr && rd_regnum[0]): rd_val_d = instret_q;
        rd_ctr: rd_val_d = cycle_q;
        default: rd_val_d = rd_cur;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LOC; i++) begin
        mem_q[i] <= '0;
      end
      cycle_q <= '0;
      instret_q <= '0;
      rd_valid_q <= 1'b0;
      rd_val_q <= '0;
      rd_fault_q <= 1'b0;
      wr_fault_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cycle_q <= cycle_d;
      instret_q <= instret_d;
      rd_valid_q <= rd_valid_d;
      rd_val_q <= rd_val_d;
      rd_fault_q <= rd_fault_d;
      wr_fault_q <= wr_fault_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_val = rd_val_q;
  assign rd_fault = rd_fault_q;
  assign wr_fault = wr_fault_q;

endmodule

// File: tb/tb_sreg_file.sv
// Bench for sreg_file: directed plan steps then random traffic,
// checked against a keyed-location reference model.
module tb_sreg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cur_plevel;
  logic        sreg_wr_en;
  logic [4:0]  sreg_wr_group;
  logic [2:0]  sreg_wr_regnum;
  logic [1:0]  sreg_wr_plevel;
  logic [31:0] sreg_wr_val;
  logic        retire_valid;
  logic        rd_en;
  logic [4:0]  rd_group;
  logic [2:0]  rd_regnum;
  logic [1:0]  rd_plevel;
  logic        rd_valid;
  logic [31:0] rd_val;
  logic        rd_fault;
  logic        wr_fault;

  sreg_file #(.REG_WIDTH(32), .NUM_GROUPS(4)) dut (
    .clk(clk), .rst(rst), .cur_plevel(cur_plevel),
    .sreg_wr_en(sreg_wr_en), .sreg_wr_group(sreg_wr_group),
    .sreg_wr_regnum(sreg_wr_regnum),
    .sreg_wr_plevel(sreg_wr_plevel),
    .sreg_wr_val(sreg_wr_val), .retire_valid(retire_valid),
    .rd_en(rd_en), .rd_group(rd_group), .rd_regnum(rd_regnum),
    .rd_plevel(rd_plevel), .rd_valid(rd_valid), .rd_val(rd_val),
    .rd_fault(rd_fault), .wr_fault(wr_fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: map from canonical location to value.
  logic [31:0] mem_m [int];
  longint unsigned cyc_m;
  longint unsigned ins_m;
  logic [31:0] ev_val;

  function automatic int key(int g, int r, int p);
    if (g == 0 && r <= 1) return r * 4;
    return g * 32 + r * 4 + p;
  endfunction

  function automatic logic [31:0] mread(int k);
    if (k == 0) return cyc_m[31:0];
    if (k == 4) return ins_m[31:0];
    if (mem_m.exists(k)) return mem_m[k];
    return 32'h0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    sreg_wr_en = 1'b0;
    sreg_wr_group = '0;
    sreg_wr_regnum = '0;
    sreg_wr_plevel = '0;
    sreg_wr_val = '0;
    retire_valid = 1'b0;
    rd_en = 1'b0;
    rd_group = '0;
    rd_regnum = '0;
    rd_plevel = '0;
  endtask

  task automatic wr(int g, int r, int p, logic [31:0] v);
    sreg_wr_en = 1'b1;
    sreg_wr_group = 5'(g);
    sreg_wr_regnum = 3'(r);
    sreg_wr_plevel = 2'(p);
    sreg_wr_val = v;
  endtask

  task automatic rd(int g, int r, int p);
    rd_en = 1'b1;
    rd_group = 5'(g);
    rd_regnum = 3'(r);
    rd_plevel = 2'(p);
  endtask

  // One clock: predict from model, clock, update model, compare.
  task automatic step(string tag);
    bit wok, rbad, ev_valid, ev_fault, ev_wf;
    int wk, rk;
    wok = sreg_wr_en && sreg_wr_group < 4
       && sreg_wr_plevel <= cur_plevel;
    wk = key(sreg_wr_group, sreg_wr_regnum, sreg_wr_plevel);
    rk = key(rd_group, rd_regnum, rd_plevel);
    rbad = rd_group >= 4 || rd_plevel > cur_plevel;
    ev_valid = rd_en;
    ev_fault = rd_en && rbad;
    ev_wf = sreg_wr_en && !wok;
    if (rd_en) begin
      if (rbad) ev_val = 32'h0;
      else if (wok && wk == rk) ev_val = sreg_wr_val;
      else ev_val = mread(rk);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mem_m.delete();
      cyc_m = 0;
      ins_m = 0;
      ev_valid = 1'b0;
      ev_fault = 1'b0;
      ev_wf = 1'b0;
      ev_val = 32'h0;
    end else begin
      cyc_m = (cyc_m + 1) % 64'h1_0000_0000;
      if (retire_valid) ins_m = (ins_m + 1) % 64'h1_0000_0000;
      if (wok) begin
        if (wk == 0) cyc_m = sreg_wr_val;
        else if (wk == 4) ins_m = sreg_wr_val;
        else mem_m[wk] = sreg_wr_val;
      end
    end
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(ev_valid));
    chk({tag, ".rd_fault"}, 32'(rd_fault), 32'(ev_fault));
    chk({tag, ".rd_val"}, rd_val, ev_val);
    chk({tag, ".wr_fault"}, 32'(wr_fault), 32'(ev_wf));
  endtask

  initial begin
    idle();
    cur_plevel = 2'd3;
    ev_val = 32'h0;
    cyc_m = 0;
    ins_m = 0;

    rst = 1'b1;
    step("reset");
    chk("reset.rd_val_const", rd_val, 32'h0);
    idle();
    for (int i = 0; i < 5; i++) step("idle");

    rd(0, 0, 0);
    step("cycle_rd");
    chk("cycle_rd.five", rd_val, 32'd5);
    idle();

    wr(1, 2, 1, 32'hDEADBEEF);
    step("wr121");
    idle();
    rd(1, 2, 1);
    step("rd121");
    chk("rd121.const", rd_val, 32'hDEADBEEF);
    idle();
    rd(1, 2, 0);
    step("rd120");
    chk("rd120.const", rd_val, 32'h0);

    idle();
    cur_plevel = 2'd0;
    wr(1, 2, 2, 32'h1234);
    step("wrpriv");
    chk("wrpriv.pulse", 32'(wr_fault), 32'd1);
    idle();
    rd(1, 0, 3);
    step("rdpriv");
    chk("rdpriv.fault", 32'(rd_fault), 32'd1);
    chk("wrpriv.clear", 32'(wr_fault), 32'd0);
    idle();
    cur_plevel = 2'd3;
    rd(1, 2, 2);
    step("rd122");
    chk("rd122.const", rd_val, 32'h0);

    idle();
    wr(5, 0, 0, 32'h55);
    rd(5, 0, 0);
    step("grp5");
    chk("grp5.wf", 32'(wr_fault), 32'd1);
    chk("grp5.rf", 32'(rd_fault), 32'd1);

    idle();
    wr(2, 7, 3, 32'hA5A5);
    rd(2, 7, 3);
    step("bypass");
    chk("bypass.const", rd_val, 32'hA5A5);

    idle();
    wr(0, 1, 2, 32'hFFFFFFFF);
    retire_valid = 1'b1;
    step("instret_wr");
    idle();
    retire_valid = 1'b1;
    rd(0, 1, 0);
    step("instret_max");
    chk("instret_max.const", rd_val, 32'hFFFFFFFF);
    idle();
    rd(0, 1, 3);
    step("instret_wrap");
    chk("instret_wrap.const", rd_val, 32'h0);

    idle();
    rd(0, 0, 0);
    rst = 1'b1;
    step("rst_mid");
    chk("rst_mid.valid", 32'(rd_valid), 32'd0);
    idle();
    rd(0, 0, 1);
    step("post_rst_cyc");
    chk("post_rst_cyc.const", rd_val, 32'h0);

    for (int i = 0; i < 600; i++) begin
      idle();
      cur_plevel = 2'($urandom_range(0, 3));
      retire_valid = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0) begin
        wr($urandom_range(0, 5), $urandom_range(0, 7),
           $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF
                                       : $urandom);
      end
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 3) == 0)
          rd(sreg_wr_group, sreg_wr_regnum, sreg_wr_plevel);
        else
          rd($urandom_range(0, 5), $urandom_range(0, 7),
             $urandom_range(0, 3));
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
